commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Hardware capture buffer for the core's retirement stream: pc, instr, reg_addr, reg_data, qualified by update.
- Filters each retired instruction by a runtime mode and stores accepted records, each tagged with a sequence number, in a first-word-fall-through (FWFT) FIFO.
- Records are drained through a valid/ready port to a debug/UART/log sink.
- Sits beside core_model. Replaces display-only tracing with a synthesizable, lossless-or-counted trace path.

Parameters:
- XLEN, riscv_pkg::XLEN (32): width of pc, instr and reg_data.
- DEPTH, 16: FIFO entries; power of 2, at least 2.
- SEQ_W, 16: width of the sequence tag and of the drop counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- update_i  in  1  one instruction retired this cycle.
- pc_i  in  XLEN  retired pc.
- instr_i  in  XLEN  retired instruction word.
- reg_addr_i  in  5  destination register; 0 means no register write.
- reg_data_i  in  XLEN  value written to rd.
- mode_i  in  2  0 ALL, 1 REGW (rd != 0 only), 2 PCWIN, 3 OFF.
- pc_lo_i  in  XLEN  PCWIN lower bound, inclusive.
- pc_hi_i  in  XLEN  PCWIN upper bound, inclusive.
- clear_i  in  1  synchronous flush.
- trace_valid_o  out  1  head record available.
- trace_ready_i  in  1  sink accepts head.
- trace_pc_o  out  XLEN  head pc.
- trace_instr_o  out  XLEN  head instruction word.
- trace_rd_o  out  5  head destination register.
- trace_data_o  out  XLEN  head register data.
- trace_seq_o  out  SEQ_W  head sequence tag.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- drop_cnt_o  out  SEQ_W  records lost to overflow.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - FIFO empty; all outputs 0, including trace_valid_o.
  - Sequence counter, count_o and drop_cnt_o are 0.
- Sequence counter:
  - Increments by 1 on every update_i=1 cycle, regardless of mode or filter result. Wraps modulo 2^SEQ_W.
  - The tag stored in a record is the counter value before that increment; the first retired instruction gets tag 0.
- Accept condition: update_i AND filter, where filter is:
  - ALL: always true.
  - REGW: reg_addr_i != 0.
  - PCWIN: pc_lo_i <= pc_i <= pc_hi_i, unsigned compare. If pc_lo_i > pc_hi_i, nothing is accepted.
  - OFF: never true.
- Push: accept AND (not full OR pop). A record pushed in cycle N is visible at the outputs in cycle N+1.
- Pop: trace_valid_o AND trace_ready_i. The head advances at the clock edge.
- Outputs are FWFT: trace_* are driven from the head entry whenever trace_valid_o=1. When empty, trace_* hold their last value and are don't-care.
- trace_valid_o = (count_o != 0).
- Full with accept and no pop: the new record is dropped and drop_cnt_o increments, saturating at 2^SEQ_W-1. FIFO contents are unchanged; the oldest records are kept.
- Full with accept and pop in the same cycle: both happen; count_o is unchanged and nothing is dropped.
- Empty with accept and trace_ready_i=1: no pop this cycle (valid is 0); the record appears the next cycle.
- Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate counter.
- clear_i (synchronous):
  - Next state is empty FIFO, sequence counter 0, drop_cnt_o 0.
  - Takes priority over push and pop in the same cycle; the concurrent update is discarded and not counted.
- Reset asserted mid-drain: all state clears immediately; no partial record is presented afterwards.
- mode_i, pc_lo_i and pc_hi_i are sampled every cycle; a change affects the next update with no pipeline delay.

Decomposition:
- riscv_pkg additions:
  - trace_entry_t packed struct {pc, instr, rd, data, seq}.
  - trace_mode_e enum {TRACE_ALL, TRACE_REGW, TRACE_PCWIN, TRACE_OFF}.
  - TRACE_SEQ_W constant.
- Sub-module trace_fifo: generic FWFT FIFO parametrised on entry type and DEPTH, with push/pop/clear, full/empty/count.
- commit_trace_buffer holds the filter, sequence counter, drop counter and the FIFO instance.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle with 3 entries stored -> trace_valid_o=0, count_o=0 and drop_cnt_o=0 immediately; first update after release carries seq 0.
- ALL mode, ready=0, updates at pc 0x80000000, 0x80000004, 0x80000008 -> count_o=3, head pc 0x80000000 seq 0. Then ready=1 -> seq 0,1,2 pop on consecutive cycles and valid drops to 0.
- REGW mode, four updates with reg_addr 0, 5, 0, 10 -> exactly two records: (rd=5, seq 1) and (rd=10, seq 3).
- DEPTH=4, ALL mode, ready=0, 6 updates -> count_o=4, drop_cnt_o=2, records seq 0..3. Then push with ready=1 while full -> count_o stays 4, drop_cnt_o stays 2, new tail seq 6.
- PCWIN lo=0x80000010 hi=0x80000020, pcs 0x8000000C, 0x80000010, 0x80000020, 0x80000024 -> two records, seq 1 and 2. Then lo=0x30 hi=0x20 -> nothing accepted.
- clear_i asserted with 2 entries, drop_cnt_o=1 and a concurrent update -> next cycle count_o=0, drop_cnt_o=0; next accepted record has seq 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-wide types and constants, including the commit-trace record
// format and filter modes used by the trace capture path.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int TRACE_SEQ_W = 16;

  typedef enum logic [1:0] {
    TRACE_ALL   = 2'd0,
    TRACE_REGW  = 2'd1,
    TRACE_PCWIN = 2'd2,
    TRACE_OFF   = 2'd3
  } trace_mode_e;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        instr;
    logic [4:0]             rd;
    logic [XLEN-1:0]        data;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;

  // Inclusive unsigned window test; an inverted window (lo > hi) matches nothing.
  function automatic logic pc_in_window(input logic [XLEN-1:0] pc,
                                        input logic [XLEN-1:0] lo,
                                        input logic [XLEN-1:0] hi);
    return (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Generic first-word-fall-through FIFO: the head entry is always visible on
// rdata; occupancy is tracked by its own counter so pointers wrap freely.
module trace_fifo #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: the storage array is reset so the head reads as all-zero after reset
  // instead of X; clear only rewinds pointers and leaves stale data in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!clear && push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement-stream capture: filters each retired instruction by mode, tags
// it with a sequence number and queues it for a valid/ready trace sink.
module commit_trace_buffer #(
  parameter int  XLEN  = riscv_pkg::XLEN,
  parameter int  DEPTH = 16,
  parameter int  SEQ_W = riscv_pkg::TRACE_SEQ_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  instr_i,
  input  logic [4:0]       reg_addr_i,
  input  logic [XLEN-1:0]  reg_data_i,
  input  logic [1:0]       mode_i,
  input  logic [XLEN-1:0]  pc_lo_i,
  input  logic [XLEN-1:0]  pc_hi_i,
  input  logic             clear_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [XLEN-1:0]  trace_pc_o,
  output logic [XLEN-1:0]  trace_instr_o,
  output logic [4:0]       trace_rd_o,
  output logic [XLEN-1:0]  trace_data_o,
  output logic [SEQ_W-1:0] trace_seq_o,
  output logic [CW-1:0]    count_o,
  output logic [SEQ_W-1:0] drop_cnt_o
);

  import riscv_pkg::*;

  logic         filter_hit;
  logic         accept;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic [SEQ_W-1:0] seq_q;
  trace_entry_t wr_entry;
  trace_entry_t head;

  // NOTE: default assigned first so no path through the case leaves
  // filter_hit unassigned and infers a latch.
  always_comb begin
    filter_hit = 1'b0;
    unique case (trace_mode_e'(mode_i))
      TRACE_ALL:   filter_hit = 1'b1;
      TRACE_REGW:  filter_hit = (reg_addr_i != 5'd0);
      TRACE_PCWIN: filter_hit = pc_in_window(pc_i, pc_lo_i, pc_hi_i);
      TRACE_OFF:   filter_hit = 1'b0;
      default:     filter_hit = 1'b0;
    endcase
  end

  assign accept = update_i && filter_hit;
  assign pop    = trace_valid_o && trace_ready_i;
  assign push   = accept && (!full || pop);

  assign wr_entry = '{pc: pc_i, instr: instr_i, rd: reg_addr_i,
                      data: reg_data_i, seq: seq_q};

  // Sequence advances on every retirement, filtered or not, so gaps in the
  // captured tags reveal how many instructions were skipped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      seq_q      <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (update_i) seq_q <= seq_q + 1'b1;
      if (accept && full && !pop && (drop_cnt_o != {SEQ_W{1'b1}}))
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  trace_fifo #(
    .entry_t (trace_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (clear_i),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  assign trace_valid_o = !empty;
  assign trace_pc_o    = head.pc;
  assign trace_instr_o = head.instr;
  assign trace_rd_o    = head.rd;
  assign trace_data_o  = head.data;
  assign trace_seq_o   = head.seq;

endmodule
